// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage ALU with registered result/zero; shifts run one bit per cycle.
// Define BARREL_SHIFT_EN to build a single-cycle barrel shifter instead (busy tied to 0).

`ifndef ALU_ADD
`define ALU_ADD  4'b0000
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'b0001
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'b0010
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'b0011
`endif
`ifndef ALU_XOR
`define ALU_XOR  4'b0100
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'b0101
`endif
`ifndef ALU_OR
`define ALU_OR   4'b0110
`endif
`ifndef ALU_AND
`define ALU_AND  4'b0111
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'b1000
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'b1101
`endif

module ex_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0]   w_shamt;
  logic            w_is_shift;
  logic [XLEN-1:0] w_alu_res;

  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  assign w_shamt    = op_b[SW-1:0];
  assign w_is_shift = (alu_sel == `ALU_SLL) || (alu_sel == `ALU_SRL) || (alu_sel == `ALU_SRA);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_alu_res = '0;
    case (alu_sel)
      `ALU_ADD:  w_alu_res = op_a + op_b;
      `ALU_SUB:  w_alu_res = op_a - op_b;
      `ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      `ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      `ALU_XOR:  w_alu_res = op_a ^ op_b;
      `ALU_OR:   w_alu_res = op_a | op_b;
      `ALU_AND:  w_alu_res = op_a & op_b;
`ifdef BARREL_SHIFT_EN
      `ALU_SLL:  w_alu_res = op_a << w_shamt;
      `ALU_SRL:  w_alu_res = op_a >> w_shamt;
      `ALU_SRA:  w_alu_res = $signed(op_a) >>> w_shamt;
`else
      // Only the shamt==0 case completes here; nonzero shifts go through the SHIFT state.
      `ALU_SLL,
      `ALU_SRL,
      `ALU_SRA:  w_alu_res = op_a;
`endif
      default:   w_alu_res = '0;
    endcase
  end

`ifdef BARREL_SHIFT_EN

  assign busy = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_alu_res;
        r_zero   <= (w_alu_res == '0);
      end
    end
  end

`else

  typedef enum logic { S_IDLE, S_SHIFT } state_t;
  typedef enum logic [1:0] { SH_SLL, SH_SRL, SH_SRA } shop_t;

  state_t          r_state;
  shop_t           r_op;
  shop_t           w_sel_op;
  logic [XLEN-1:0] r_acc;
  logic [SW-1:0]   r_cnt;
  logic [XLEN-1:0] w_acc_next;

  assign w_sel_op = (alu_sel == `ALU_SRA) ? SH_SRA :
                    (alu_sel == `ALU_SRL) ? SH_SRL : SH_SLL;

  always_comb begin
    w_acc_next = r_acc;
    case (r_op)
      SH_SLL:  w_acc_next = {r_acc[XLEN-2:0], 1'b0};
      SH_SRL:  w_acc_next = {1'b0, r_acc[XLEN-1:1]};
      SH_SRA:  w_acc_next = {r_acc[XLEN-1], r_acc[XLEN-1:1]};
      default: w_acc_next = r_acc;
    endcase
  end

  // Stall is requested while a shift still has more than one bit to go.
  always_comb begin
    busy = 1'b0;
    if (rst && !flush) begin
      if (r_state == S_SHIFT) busy = (r_cnt > SW'(1));
      else                    busy = in_valid && w_is_shift && (w_shamt != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op        <= SH_SLL;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_out_valid <= 1'b0;
          if (in_valid) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_acc   <= op_a;
              r_cnt   <= w_shamt;
              r_op    <= w_sel_op;
              r_state <= S_SHIFT;
            end else begin
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_out_valid <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_acc       <= w_acc_next;
          r_cnt       <= r_cnt - SW'(1);
          r_out_valid <= 1'b0;
          if (r_cnt == SW'(1)) begin
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`endif

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: stimulus pushes expected result/zero/cycle, a negedge monitor checks.
// Follows the build of the DUT: BARREL_SHIFT_EN selects single-cycle shift expectations.

module tb_ex_alu_unit;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_BAD  = 4'b1111;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            z;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic [3:0]      alu_sel = OP_ADD;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;

  int              cyc = 0;
  int              n_tests = 0;
  int              n_fail = 0;
  bit              mon_en = 1'b0;
  logic [XLEN-1:0] last_res = '0;
  exp_t            sb_q[$];
  exp_t            mon_e;
  logic            mon_v;

  ex_alu_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .alu_sel   (alu_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction at posedge+1 and hold it until it is accepted.
  task automatic issue(input logic [3:0] sel, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] res);
    int lat;
    int k;
    k   = int'(b[4:0]);
    lat = 1;
`ifndef BARREL_SHIFT_EN
    if (((sel == OP_SLL) || (sel == OP_SRL) || (sel == OP_SRA)) && (k != 0)) lat = k + 1;
`endif
    alu_sel  = sel;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    flush    = 1'b0;
    sb_q.push_back('{res: res, z: (res == '0), cyc: cyc + lat});
    last_res = res;
    for (int i = 1; i < lat; i++) begin
      #1;
      check("busy_shift", 32'(busy), 32'd1);
      step();
    end
    #1;
    check("busy_done", 32'(busy), 32'd0);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_v = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
      check("out_valid", 32'(out_valid), 32'(mon_v));
      if (mon_v) begin
        mon_e = sb_q.pop_front();
        check("result", result, mon_e.res);
        check("zero", 32'(zero), 32'(mon_e.z));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a valid instruction present.
    rst = 1'b0; in_valid = 1'b1; alu_sel = OP_ADD; op_a = 32'hFFFF_FFFF; op_b = 32'd1;
    step();
    mon_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy2", 32'(busy), 32'd0);
    rst = 1'b1;

    // Back-to-back single-cycle ops.
    issue(OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0);
    issue(OP_SUB,  32'd5,         32'd5,         32'd0);
    issue(OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    issue(OP_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0);
    issue(OP_SLTU, 32'd1,         32'hFFFF_FFFF, 32'd1);
    issue(OP_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000);
    issue(OP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE);
    issue(OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    issue(OP_OR,   32'h0000_00A0, 32'h0000_0005, 32'h0000_00A5);
    issue(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    issue(OP_BAD,  32'h0000_0123, 32'h0000_0456, 32'd0);
    idle();

    // Shifts: arithmetic fill, shamt 0, maximum shamt, upper op_b bits ignored.
    issue(OP_SRA, 32'h8000_0000, 32'd4,         32'hF800_0000);
    issue(OP_SLL, 32'h0000_1234, 32'd0,         32'h0000_1234);
    issue(OP_SRA, 32'h4000_0000, 32'd2,         32'h1000_0000);
    issue(OP_SRL, 32'h8000_0000, 32'd31,        32'h0000_0001);
    issue(OP_SLL, 32'h0000_0001, 32'd31,        32'h8000_0000);
    issue(OP_SLL, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006);
    idle();

    // Instruction presented together with flush is discarded.
    alu_sel = OP_ADD; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_hold", result, last_res);
    check("flush_zero_hold", 32'(zero), 32'(last_res == '0));
    step();

`ifndef BARREL_SHIFT_EN
    // Flush in the third SHIFT cycle of an SRL by 8.
    alu_sel = OP_SRL; op_a = 32'h1234_5678; op_b = 32'd8; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fl_busy", 32'(busy), 32'd1);
      step();
    end
    flush = 1'b1;
    #1;
    check("fl_busy_drop", 32'(busy), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_result_hold", result, last_res);
    check("fl_zero_hold", 32'(zero), 32'(last_res == '0));
    issue(OP_ADD, 32'd10, 32'd20, 32'd30);
    idle();

    // Reset in the fifth SHIFT cycle of an SLL by 20.
    alu_sel = OP_SLL; op_a = 32'hDEAD_BEEF; op_b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rm_busy", 32'(busy), 32'd1);
      step();
    end
    rst = 1'b0;
    #1;
    check("rm_busy_rst", 32'(busy), 32'd0);
    step();
    check("rm_out_valid", 32'(out_valid), 32'd0);
    check("rm_result", result, 32'd0);
    check("rm_zero", 32'(zero), 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    last_res = '0;
    #1;
    check("rm_busy_idle", 32'(busy), 32'd0);
    step();
`endif

    issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00);
    idle();
    idle();
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
# ex_alu_unit

Execute-stage arithmetic unit of the pipelined RISC-V core. It sits directly downstream of the ALU control unit, consuming its 4-bit `ALU_Sel` with the two operands selected in EX. It produces a registered result and zero flag for the EX/MEM register. Shifts run iteratively, one bit per cycle, by default. While a multi-cycle shift is in flight, `busy` tells the hazard unit to stall IF/ID/ID-EX.

## Interface
- `XLEN`, default 32: operand/result width (shift amount uses the low log2(XLEN) bits of `op_b`).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  an instruction is present in EX this cycle.
- `alu_sel`  in  4  operation, encoded with the `ALU_*` macros from defines.v (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- `op_a`  in  XLEN  first operand (rs1 or PC).
- `op_b`  in  XLEN  second operand (rs2 or immediate).
- `flush`  in  1  kill the EX instruction (branch mispredict/exception).
- `busy`  out  1  combinational; stall request to hazard unit.
- `out_valid`  out  1  `result`/`zero` hold a new value this cycle.
- `result`  out  XLEN  registered ALU result.
- `zero`  out  1  registered, 1 when the registered result == 0.

## Operation
- States: IDLE, SHIFT. Internal: accumulator `acc` (XLEN), counter `cnt` (log2(XLEN) bits), latched op (SLL/SRL/SRA).
- IDLE, `in_valid`=1, non-shift op or shift with shamt=0: compute and register `result`/`zero`; `out_valid`=1 next cycle; stay IDLE.
- IDLE, `in_valid`=1, shift with shamt k>0: `acc`<=`op_a`, `cnt`<=k, latch op, go to SHIFT. `busy`=1 this cycle.
- SHIFT: each cycle, shift `acc` by one in the latched direction and decrement `cnt`. SRA fills with `acc[XLEN-1]`; SLL/SRL fill with 0.
- SHIFT, `cnt`>1: `busy`=1, `out_valid`=0 next cycle.
- SHIFT, `cnt`==1: `busy`=0. Write the shifted value to `result`/`zero`; `out_valid`=1 next cycle; go to IDLE.
- Inputs are ignored in SHIFT. Upstream holds the same shift instruction in ID/EX while stalled.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare; SLTU is unsigned. Both yield 1 or 0, zero-extended.
  - Logic ops are bitwise.
- Unrecognised `alu_sel`: `result`=0, `zero`=1, `out_valid`=1.
- `in_valid`=0 in IDLE: `out_valid`=0 next cycle; `result`/`zero` hold their previous values.
- `flush` takes priority over everything:
  - State goes to IDLE and `out_valid`=0 next cycle.
  - `result`/`zero` hold their values; `busy`=0 in the flush cycle.
  - An instruction presented with `flush` is discarded.
- `rst`=0, sampled on an edge: state IDLE, `acc`=0, `cnt`=0, `result`=0, `zero`=0, `out_valid`=0. This aborts any shift mid-operation; `busy` is 0 while `rst`=0.

## Timing
- Non-shift op or shamt=0, accepted in cycle n: `result`/`out_valid` in cycle n+1; `busy` never asserted.
- Shift with shamt k>0, presented in cycle n:
  - `busy`=1 in cycles n..n+k-1 and 0 in cycle n+k.
  - `result` and a 1-cycle `out_valid` pulse in cycle n+k+1.
  - The next instruction can be accepted in cycle n+k+1.
- Back-to-back single-cycle ops: one result per cycle; `out_valid` stays high.
- Maximum shift (k=XLEN-1) takes XLEN cycles in EX.
- `out_valid` is high for exactly one cycle per completed instruction.

## Configuration
- `BARREL_SHIFT_EN` defined:
  - All shifts complete in one cycle like other ops, using a combinational barrel shifter.
  - The SHIFT state, `acc` and `cnt` are not built; `busy` is tied to 0.
- Not defined: iterative shifting as described in Operation and Timing.
- The result values are identical in both builds; only latency and `busy` differ.

## Test plan
- Reset: hold `rst`=0 two cycles with `in_valid`=1 -> `out_valid`=0, `result`=0, `zero`=0, `busy`=0.
- ADD 0xFFFFFFFF+1, then SUB 5-5, then SLT 0xFFFFFFFF vs 1 on consecutive cycles:
  - `result` 0 (`zero`=1), 0 (`zero`=1), 1 on consecutive cycles, with `out_valid` high throughout.
  - Same SLT operands under SLTU -> 0.
- SRA `op_a`=0x80000000, shamt=4, iterative build:
  - `busy` high exactly 4 cycles.
  - `result`=0xF8000000 in cycle n+5, with a single `out_valid` pulse.
- SLL shamt=0 with `op_a`=0x1234 -> 0x1234 next cycle, `busy` never high. With `BARREL_SHIFT_EN`, SLL shamt=31 of 1 -> 0x80000000 next cycle, `busy`=0.
- SRL shamt=8, `flush` in the third SHIFT cycle:
  - `busy` drops that cycle, no `out_valid` pulse, `result` unchanged.
  - The following ADD is accepted normally.
- `rst`=0 mid-shift (shamt=20, cycle 5): state IDLE, all outputs zero next cycle. After release, an XOR 0xF0F0^0x0FF0 -> 0xFF00.
